fpga_cfg_loader: RTL and testbench
==================================

Name: fpga_cfg_loader

Overview:
Synthesizable bitstream loader for the `fpga` fabric. It replaces the file-driven simulation loader in per-design wrappers.
- Accepts configuration frames over a valid/ready stream.
- Writes each frame into the fabric with a one-hot `configs_en` strobe.
- After the last frame, waits a settle interval, raises `ff_en`, waits again, then raises `rdy`.
- Supports re-configuration on a new `start`, back-pressure, and (optionally) a checksum frame.

Parameters:
- CFG_W, 320: configuration frame width in bits (matches fabric `configs_in`).
- NUM_FRAMES, 172: number of frames (matches fabric `configs_en` width).
- SETTLE_CYC, 10: idle cycles after the last write before `ff_en` rises, and again between `ff_en` and `rdy`; minimum 1.

Ports:
- clock, in, 1: sole clock, rising edge.
- rst, in, 1: asynchronous active-low reset.
- start, in, 1: begin (re)configuration; single-cycle pulse or level; sampled only in IDLE or READY.
- cfg_data, in, CFG_W: incoming frame word.
- cfg_valid, in, 1: cfg_data valid.
- cfg_ready, out, 1: loader accepts a word this cycle.
- configs_in, out, CFG_W: frame data to fabric.
- configs_en, out, NUM_FRAMES: one-hot frame write strobe to fabric.
- ff_en, out, 1: fabric flip-flop enable.
- rdy, out, 1: configured design running.
- busy, out, 1: high in LOAD, SETTLE or ARM.
- err, out, 1: sticky checksum error (tied 0 without the optional feature).
- frame_cnt, out, $clog2(NUM_FRAMES+1): number of frames written so far.

Behaviour:
- Reset: all outputs 0 (configs_in, configs_en, ff_en, rdy, busy, err, frame_cnt, cfg_ready); state is IDLE. Reset is asynchronous; it aborts any state and clears all outputs immediately.
- IDLE: cfg_ready=0. When start=1, go to LOAD, clear frame_cnt and err, and drop ff_en and rdy.
- LOAD: cfg_ready=1. A word is accepted when cfg_valid & cfg_ready.
  - On the cycle after acceptance: configs_in = word, and configs_en = (1 << frame_cnt) for exactly one cycle; frame_cnt then increments.
  - configs_in holds its last value between writes; configs_en is 0 when no write is occurring.
  - A cfg_valid gap inserts idle cycles; no strobe occurs.
  - Back-to-back acceptance is allowed: one word per cycle, so configs_en walks the one-hot bit each cycle.
  - When the NUM_FRAMES-th word is accepted, cfg_ready drops in the same cycle (combinational on state and count) and the loader goes to SETTLE.
- SETTLE: counts SETTLE_CYC cycles after the final strobe, then goes to ARM and asserts ff_en=1.
- ARM: counts SETTLE_CYC cycles, then goes to READY and asserts rdy=1.
- READY: ff_en=1, rdy=1, busy=0.
  - start=1: re-configuration. ff_en and rdy drop the next cycle and the loader goes to LOAD.
  - cfg_valid is ignored.
- start during LOAD, SETTLE or ARM is ignored.
- cfg_valid outside LOAD is ignored; no words are consumed.
- Latency for back-to-back frames: rdy rises NUM_FRAMES + 2·SETTLE_CYC + 2 cycles after the first acceptance.

Optional Feature:
- Macro: CFG_LOADER_CHECKSUM_EN.
- With the macro defined:
  - LOAD expects NUM_FRAMES+1 words. The final word is the XOR of all NUM_FRAMES data words and is not written to the fabric (no strobe).
  - Match: proceed to SETTLE.
  - Mismatch: err=1 (sticky until the next start or reset), return to IDLE, ff_en and rdy stay 0, configs_en stays 0.
- Without the macro: exactly NUM_FRAMES words are accepted, no checksum frame is expected, and err is constant 0.

Test Plan:
- Settings for all scenarios: CFG_W=8, NUM_FRAMES=4, SETTLE_CYC=3.
- Reset mid-SETTLE: assert rst low → all outputs 0 immediately, asynchronously, with no clock edge required.
- Back-to-back load: start, then words 0x11, 0x22, 0x33, 0x44 on consecutive valid cycles →
  - configs_en = 0001, 0010, 0100, 1000 on consecutive cycles, with configs_in = 0x11..0x44 alongside;
  - ff_en rises 3 cycles after the last strobe;
  - rdy rises 3 cycles after ff_en;
  - total 12 cycles from the first acceptance to rdy.
- Gapped valid: one idle cycle between each of the four words → no strobe on gap cycles, configs_in holds its value, and the walk order is unchanged.
- Re-configure from READY: assert start → ff_en and rdy are 0 the next cycle, frame_cnt=0, and a second load with 0xA0..0xA3 completes normally.
- Ignored inputs: start pulses during LOAD and cfg_valid held high while in IDLE → no state change and no strobe.
- Checksum (macro defined): words 0x11, 0x22, 0x33, 0x44 then 0x44 (correct XOR) → rdy rises. Same words then 0x00 → err=1, state IDLE, ff_en=0.

Source files
------------

// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader: streams configuration frames into the fpga fabric, then
// sequences ff_en and rdy after two settle intervals.
// Optional feature macro: CFG_LOADER_CHECKSUM_EN -- the load expects one extra
// word holding the XOR of all data words. A mismatch sets a sticky err and
// returns to IDLE without enabling the fabric.
module fpga_cfg_loader #(
    parameter int CFG_W      = 320,
    parameter int NUM_FRAMES = 172,
    parameter int SETTLE_CYC = 10
) (
    input  logic                              clock,
    input  logic                              rst,
    input  logic                              start,
    input  logic [CFG_W-1:0]                  cfg_data,
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    output logic [CFG_W-1:0]                  configs_in,
    output logic [NUM_FRAMES-1:0]             configs_en,
    output logic                              ff_en,
    output logic                              rdy,
    output logic                              busy,
    output logic                              err,
    output logic [$clog2(NUM_FRAMES+1)-1:0]   frame_cnt
);

    localparam int FCW = $clog2(NUM_FRAMES + 1);
    localparam int SCW = $clog2(SETTLE_CYC + 1);

    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYC);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        ARM,
        READY
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [SCW-1:0] settle_cnt;
    logic           accept;
    logic           do_start;
    logic           do_write;
    logic           go_arm;
    logic           go_ready;
    logic           csum_bad;

    assign accept = cfg_valid & cfg_ready;

`ifdef CFG_LOADER_CHECKSUM_EN
    logic [CFG_W-1:0] csum_q;
    logic             csum_phase;

    // All data frames written; the next accepted word is the checksum.
    assign csum_phase = (frame_cnt == FCW'(NUM_FRAMES));
`else
    logic             frame_last;

    assign frame_last = (frame_cnt == FCW'(NUM_FRAMES - 1));
`endif

    // State register.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, combinational handshake outputs and datapath strobes.
    always_comb begin
        state_d   = state_q;
        cfg_ready = 1'b0;
        busy      = 1'b0;
        do_start  = 1'b0;
        do_write  = 1'b0;
        go_arm    = 1'b0;
        go_ready  = 1'b0;
        csum_bad  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = LOAD;
                    do_start = 1'b1;
                end
            end
            LOAD: begin
                busy      = 1'b1;
                cfg_ready = 1'b1;
                if (accept) begin
`ifdef CFG_LOADER_CHECKSUM_EN
                    if (csum_phase) begin
                        if (cfg_data == csum_q) begin
                            state_d = SETTLE;
                        end else begin
                            state_d  = IDLE;
                            csum_bad = 1'b1;
                        end
                    end else begin
                        do_write = 1'b1;
                    end
`else
                    do_write = 1'b1;
                    if (frame_last) begin
                        state_d = SETTLE;
                    end
`endif
                end
            end
            SETTLE: begin
                busy = 1'b1;
                if (settle_cnt == SETTLE_LAST) begin
                    state_d = ARM;
                    go_arm  = 1'b1;
                end
            end
            ARM: begin
                busy = 1'b1;
                if (settle_cnt == SETTLE_LAST) begin
                    state_d  = READY;
                    go_ready = 1'b1;
                end
            end
            READY: begin
                if (start) begin
                    state_d  = LOAD;
                    do_start = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Settle/arm interval counter, restarted on every state change.
    // The checksum word occupies the cycle after the last strobe, so SETTLE
    // starts one count ahead to keep ff_en timed from the final strobe.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            settle_cnt <= '0;
        end else if (state_d != state_q) begin
`ifdef CFG_LOADER_CHECKSUM_EN
            settle_cnt <= (state_d == SETTLE) ? SCW'(1) : '0;
`else
            settle_cnt <= '0;
`endif
        end else if (state_q == SETTLE || state_q == ARM) begin
            settle_cnt <= settle_cnt + SCW'(1);
        end
    end

    // Frame write datapath: one-hot strobe one cycle after acceptance.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            configs_in <= '0;
            configs_en <= '0;
            frame_cnt  <= '0;
            ff_en      <= 1'b0;
            rdy        <= 1'b0;
        end else begin
            configs_en <= '0;
            if (do_start) begin
                frame_cnt <= '0;
                ff_en     <= 1'b0;
                rdy       <= 1'b0;
            end
            if (do_write) begin
                configs_in <= cfg_data;
                configs_en <= NUM_FRAMES'(1) << frame_cnt;
                frame_cnt  <= frame_cnt + FCW'(1);
            end
            if (go_arm) begin
                ff_en <= 1'b1;
            end
            if (go_ready) begin
                rdy <= 1'b1;
            end
        end
    end

`ifdef CFG_LOADER_CHECKSUM_EN
    // Running XOR of written frames and sticky checksum error flag.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            csum_q <= '0;
            err    <= 1'b0;
        end else begin
            if (do_start) begin
                csum_q <= '0;
                err    <= 1'b0;
            end else if (do_write) begin
                csum_q <= csum_q ^ cfg_data;
            end
            if (csum_bad) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Testbench for fpga_cfg_loader (CFG_W=8, NUM_FRAMES=4, SETTLE_CYC=3).
// Reference model tracks accepted words and event times arithmetically.
module tb_fpga_cfg_loader;

    localparam int CW    = 8;
    localparam int NF    = 4;
    localparam int SC    = 3;
    localparam int FW    = $clog2(NF + 1);
    localparam int NEVER = 1 << 30;
`ifdef CFG_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic          clock;
    logic          rst;
    logic          start;
    logic [CW-1:0] cfg_data;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [CW-1:0] configs_in;
    logic [NF-1:0] configs_en;
    logic          ff_en;
    logic          rdy;
    logic          busy;
    logic          err;
    logic [FW-1:0] frame_cnt;

    fpga_cfg_loader #(
        .CFG_W      (CW),
        .NUM_FRAMES (NF),
        .SETTLE_CYC (SC)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .start      (start),
        .cfg_data   (cfg_data),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .configs_in (configs_in),
        .configs_en (configs_en),
        .ff_en      (ff_en),
        .rdy        (rdy),
        .busy       (busy),
        .err        (err),
        .frame_cnt  (frame_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_assert;
    int n_fail;
    int cyc;

    // Reference model state
    bit            m_loading;
    bit            m_idle;
    int            m_taken;
    int            m_t_ff;
    int            m_t_rdy;
    bit            m_err;
    logic [CW-1:0] m_last_in;
    logic [CW-1:0] m_xor;
    logic [NF-1:0] m_en;

    logic [CW-1:0] wq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_loading = 1'b0;
        m_idle    = 1'b1;
        m_taken   = 0;
        m_t_ff    = NEVER;
        m_t_rdy   = NEVER;
        m_err     = 1'b0;
        m_last_in = '0;
        m_xor     = '0;
        m_en      = '0;
    endtask

    task automatic check_outputs(input string where);
        chk({where, ":cfg_ready"},  32'(cfg_ready),  32'(m_loading));
        chk({where, ":configs_en"}, 32'(configs_en), 32'(m_en));
        chk({where, ":configs_in"}, 32'(configs_in), 32'(m_last_in));
        chk({where, ":frame_cnt"},  32'(frame_cnt),  32'(m_taken));
        chk({where, ":ff_en"},      32'(ff_en),      32'(cyc >= m_t_ff));
        chk({where, ":rdy"},        32'(rdy),        32'(cyc >= m_t_rdy));
        chk({where, ":busy"},       32'(busy),       32'(m_loading || (!m_idle && cyc < m_t_rdy)));
        chk({where, ":err"},        32'(err),        32'(m_err));
    endtask

    // One clock: decide the model's reaction to current inputs, advance, check.
    task automatic step(input string where);
        bit            st;
        bit            acc;
        logic [CW-1:0] d;
        st  = start && !m_loading && (m_idle || cyc >= m_t_rdy);
        acc = m_loading && cfg_valid;
        d   = cfg_data;
        @(posedge clock);
        #1;
        cyc++;
        m_en = '0;
        if (!rst) begin
            model_reset();
        end else if (st) begin
            m_loading = 1'b1;
            m_idle    = 1'b0;
            m_taken   = 0;
            m_t_ff    = NEVER;
            m_t_rdy   = NEVER;
            m_err     = 1'b0;
            m_xor     = '0;
        end else if (acc) begin
            if (m_taken < NF) begin
                m_en      = NF'(1) << m_taken;
                m_last_in = d;
                m_xor     = m_xor ^ d;
                m_taken++;
                if (!CK && m_taken == NF) begin
                    m_loading = 1'b0;
                    m_t_ff    = cyc + SC + 1;
                    m_t_rdy   = cyc + 2 * SC + 2;
                end
            end else begin
                m_loading = 1'b0;
                if (d == m_xor) begin
                    m_t_ff  = cyc + SC;
                    m_t_rdy = cyc + 2 * SC + 1;
                end else begin
                    m_err  = 1'b1;
                    m_idle = 1'b1;
                end
            end
        end
        check_outputs(where);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step("start");
        start = 1'b0;
    endtask

    // Send queued words; gap=1 inserts one invalid cycle after each word.
    task automatic send_words(input bit gap, input bit poke_start);
        foreach (wq[i]) begin
            cfg_valid = 1'b1;
            cfg_data  = wq[i];
            start     = poke_start;
            step("word");
            start     = 1'b0;
            if (gap) begin
                cfg_valid = 1'b0;
                cfg_data  = CW'($urandom);
                step("gap");
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic add_checksum(input bit good);
        logic [CW-1:0] x;
        x = '0;
        foreach (wq[i]) x ^= wq[i];
        wq.push_back(good ? x : ~x);
    endtask

    task automatic wait_rdy(input string where);
        for (int i = 0; i < 60 && !rdy; i++) step(where);
        chk({where, ":rdy_timeout"}, 32'(rdy), 32'(1));
    endtask

    int acc_cyc;

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        cyc       = 0;
        start     = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        model_reset();

        rst = 1'b1;
        #1 rst = 1'b0;
        #1 check_outputs("reset");
        step("reset_hold");
        #2 rst = 1'b1;

        // cfg_valid in IDLE is ignored
        for (int i = 0; i < 3; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = CW'($urandom);
            step("idle_valid");
        end
        cfg_valid = 1'b0;

        // Back-to-back load with end-to-end latency check
        pulse_start();
        wq = '{8'h11, 8'h22, 8'h33, 8'h44};
        acc_cyc = cyc + 1;
        if (CK) add_checksum(1'b1);
        send_words(1'b0, 1'b0);
        wait_rdy("b2b");
        chk("b2b:latency", 32'(cyc - acc_cyc + 1), 32'(NF + 2 * SC + 2));
        for (int i = 0; i < 3; i++) step("ready_hold");

        // Re-configure from READY, cfg_valid ignored while READY
        cfg_valid = 1'b1;
        cfg_data  = 8'h5A;
        step("ready_valid");
        cfg_valid = 1'b0;
        pulse_start();
        wq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        if (CK) add_checksum(1'b1);
        send_words(1'b0, 1'b0);
        wait_rdy("reconf");

        // Gapped valid with random data, start pokes during LOAD ignored
        pulse_start();
        wq.delete();
        for (int i = 0; i < NF; i++) wq.push_back(CW'($urandom));
        if (CK) add_checksum(1'b1);
        send_words(1'b1, 1'b1);
        wait_rdy("gapped");

        // Random load, then async reset in the middle of SETTLE
        pulse_start();
        wq.delete();
        for (int i = 0; i < NF; i++) wq.push_back(CW'($urandom));
        if (CK) add_checksum(1'b1);
        send_words(1'b0, 1'b0);
        step("settle");
        #2 rst = 1'b0;
        #1 model_reset();
        check_outputs("async_reset");
        step("reset_hold2");
        #2 rst = 1'b1;
        step("post_reset");

`ifdef CFG_LOADER_CHECKSUM_EN
        // Good checksum, then bad checksum
        pulse_start();
        wq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        send_words(1'b0, 1'b0);
        wait_rdy("ck_good");
        pulse_start();
        wq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        send_words(1'b0, 1'b0);
        for (int i = 0; i < 2 * SC + 4; i++) step("ck_bad");
        chk("ck_bad:err", 32'(err), 32'(1));
        // Recovery after error
        pulse_start();
        wq.delete();
        for (int i = 0; i < NF; i++) wq.push_back(CW'($urandom));
        add_checksum(1'b1);
        send_words(1'b1, 1'b0);
        wait_rdy("ck_recover");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
